user_io_sched: RTL and testbench

// Per-pin mode controller for the user-project I/O boundary between user-project pins and fabric pins.

---
 rtl/user_io_sched_if.sv | 30 +++
 rtl/user_io_sched.sv | 122 ++++++++++++
 tb/tb_user_io_sched.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/user_io_sched_if.sv
// Configuration handshake between the SoC-side control logic and the user I/O mode controller.
// The master side offers mode words; the slave side (the controller) reports status and readback.
interface user_io_sched_if #(
  parameter int NPINS = 16
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [2*NPINS-1:0]   cfg_data;
  logic                 cfg_busy;
  logic [7:0]           cfg_count;
  logic [2*NPINS-1:0]   mode_o;

  modport master (
    output cfg_valid,
    output cfg_data,
    input  cfg_ready,
    input  cfg_busy,
    input  cfg_count,
    input  mode_o
  );

  modport slave (
    input  cfg_valid,
    input  cfg_data,
    output cfg_ready,
    output cfg_busy,
    output cfg_count,
    output mode_o
  );
endinterface

// File: rtl/user_io_sched.sv
// Per-pin direction controller for the user-project I/O boundary. A new mode word is applied only
// after every pin output has been held low for SETTLE cycles, so no pin glitches through a mixed mode.
module user_io_sched #(
  parameter int                 NPINS      = 16,
  parameter int                 SETTLE     = 4,
  parameter logic [2*NPINS-1:0] RESET_MODE = '0
) (
  input  logic              UserCLK,
  input  logic              resetn,
  user_io_sched_if.slave    cfg,
  input  logic [NPINS-1:0]  fin,
  input  logic [NPINS-1:0]  uin,
  output logic [NPINS-1:0]  uout,
  output logic [NPINS-1:0]  fout
);

  if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
    $error("user_io_sched: SETTLE must lie in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_APPLY = 2'd2
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [2*NPINS-1:0] pend_q, pend_d;
  logic [2*NPINS-1:0] mode_q, mode_d;
  logic [7:0]         count_q, count_d;
  logic [NPINS-1:0]   uout_q, uout_d;
  logic [NPINS-1:0]   fout_q, fout_d;

  // Per-pin direction enables extracted from the applied mode word.
  logic [NPINS-1:0]   en_to_user;
  logic [NPINS-1:0]   en_to_fabric;

  for (genvar i = 0; i < NPINS; i++) begin : g_pin
    assign en_to_user[i]   = mode_q[2*i];
    assign en_to_fabric[i] = mode_q[2*i+1];
  end

  // NOTE: every signal gets its default before any branch, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    count_d = count_q;

    unique case (state_q)
      S_IDLE: begin
        if (cfg.cfg_valid) begin
          pend_d  = cfg.cfg_data;
          cnt_d   = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        mode_d  = pend_q;
        count_d = count_q + 8'd1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are forced low whenever a reconfiguration is in flight; this sample uses the mode
  // as it stands before the edge, so the accepting edge still passes data with the old mode.
  always_comb begin
    uout_d = '0;
    fout_d = '0;
    if (state_q == S_IDLE) begin
      uout_d = en_to_user   & fin;
      fout_d = en_to_fabric & uin;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      mode_q  <= RESET_MODE;
      count_q <= '0;
      uout_q  <= '0;
      fout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      count_q <= count_d;
      uout_q  <= uout_d;
      fout_q  <= fout_d;
    end
  end

  assign cfg.cfg_ready = (state_q == S_IDLE);
  assign cfg.cfg_busy  = (state_q == S_DRAIN) || (state_q == S_APPLY);
  assign cfg.cfg_count = count_q;
  assign cfg.mode_o    = mode_q;
  assign uout          = uout_q;
  assign fout          = fout_q;

  a_ready_busy_exclusive : assert property (
    @(posedge UserCLK) disable iff (!resetn) cfg.cfg_ready != cfg.cfg_busy
  );

endmodule

// File: tb/tb_user_io_sched.sv
// Directed bench for user_io_sched: reset, pass-through, drain timing, back-to-back configs,
// reset during reconfiguration and configuration-counter wrap.
module tb_user_io_sched;

  localparam int NPINS  = 16;
  localparam int SETTLE = 4;

  logic             UserCLK;
  logic             resetn;
  logic [NPINS-1:0] fin;
  logic [NPINS-1:0] uin;
  logic [NPINS-1:0] uout;
  logic [NPINS-1:0] fout;

  int checks   = 0;
  int failures = 0;

  user_io_sched_if #(.NPINS(NPINS)) cfg ();

  user_io_sched #(
    .NPINS     (NPINS),
    .SETTLE    (SETTLE),
    .RESET_MODE('0)
  ) dut (
    .UserCLK (UserCLK),
    .resetn  (resetn),
    .cfg     (cfg.slave),
    .fin     (fin),
    .uin     (uin),
    .uout    (uout),
    .fout    (fout)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    #1;
  endtask

  // Offers one word at the next edge, then waits (bounded) for ready; returns ready-low cycle count.
  task automatic cfg_apply(input logic [31:0] data, output int low_cycles);
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = data;
    tick();
    cfg.cfg_valid = 1'b0;
    low_cycles = 0;
    while (!cfg.cfg_ready && low_cycles < 20) begin
      low_cycles++;
      tick();
    end
    if (!cfg.cfg_ready) check("cfg_ready_timeout", 32'(cfg.cfg_ready), 32'd1);
  endtask

  int         low;
  logic [7:0] cnt_before;

  initial begin
    resetn        = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_data  = '0;
    fin           = 16'hFFFF;
    uin           = 16'hFFFF;

    // T1: reset state with all inputs high
    repeat (3) tick();
    check("rst_uout",  32'(uout), 32'h0);
    check("rst_fout",  32'(fout), 32'h0);
    check("rst_mode",  cfg.mode_o, 32'h0);
    check("rst_ready", 32'(cfg.cfg_ready), 32'd1);
    check("rst_busy",  32'(cfg.cfg_busy), 32'd0);
    check("rst_count", 32'(cfg.cfg_count), 32'd0);
    resetn = 1'b1;
    tick();
    check("idle_disabled_uout", 32'(uout), 32'h0);

    // T2: fabric->user on all pins
    fin = 16'hA5A5;
    uin = 16'hFFFF;
    cfg_apply(32'h5555_5555, low);
    check("pass_ready_low_cycles", low, SETTLE + 1);
    check("pass_mode", cfg.mode_o, 32'h5555_5555);
    check("pass_count", 32'(cfg.cfg_count), 32'd1);
    check("pass_uout_at_apply", 32'(uout), 32'h0);
    tick();
    check("pass_uout", 32'(uout), 32'hA5A5);
    check("pass_fout", 32'(fout), 32'h0);

    // T3: both directions, one-cycle latency
    fin = 16'h1234;
    uin = 16'hABCD;
    cfg_apply(32'hFFFF_FFFF, low);
    tick();
    check("bidir_uout", 32'(uout), 32'h1234);
    check("bidir_fout", 32'(fout), 32'hABCD);
    fin = 16'h5678;
    check("bidir_uout_hold", 32'(uout), 32'h1234);
    tick();
    check("bidir_uout_next", 32'(uout), 32'h5678);
    fin = 16'h1234;
    tick();

    // T4: drain window from bidir to user->fabric only
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = 32'hAAAA_AAAA;
    tick();
    cfg.cfg_valid = 1'b0;
    check("drain_e0_old_mode", 32'(uout), 32'h1234);
    check("drain_e0_busy", 32'(cfg.cfg_busy), 32'd1);
    for (int i = 1; i <= SETTLE + 1; i++) begin
      tick();
      check($sformatf("drain_e%0d_uout", i), 32'(uout), 32'h0);
      check($sformatf("drain_e%0d_fout", i), 32'(fout), 32'h0);
    end
    check("drain_mode", cfg.mode_o, 32'hAAAA_AAAA);
    check("drain_ready", 32'(cfg.cfg_ready), 32'd1);
    tick();
    check("drain_after_fout", 32'(fout), 32'hABCD);
    check("drain_after_uout", 32'(uout), 32'h0);

    // T5: valid held through DRAIN is ignored, then accepted on the first IDLE cycle
    cnt_before    = cfg.cfg_count;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = 32'hFFFF_FFFF;
    tick();
    cfg.cfg_data  = 32'h0000_0001;
    for (int i = 1; i <= SETTLE; i++) begin
      tick();
      check($sformatf("b2b_e%0d_mode", i), cfg.mode_o, 32'hAAAA_AAAA);
    end
    tick();
    check("b2b_first_mode", cfg.mode_o, 32'hFFFF_FFFF);
    check("b2b_first_ready", 32'(cfg.cfg_ready), 32'd1);
    tick();
    cfg.cfg_valid = 1'b0;
    check("b2b_second_accepted", 32'(cfg.cfg_ready), 32'd0);
    low = 1;
    while (!cfg.cfg_ready && low < 20) begin
      low++;
      tick();
    end
    check("b2b_second_ready", 32'(cfg.cfg_ready), 32'd1);
    check("b2b_second_mode", cfg.mode_o, 32'h0000_0001);
    check("b2b_count", 32'(cfg.cfg_count), 32'(8'(cnt_before + 8'd2)));
    fin = 16'h00FF;
    uin = 16'hFFFF;
    tick();
    tick();
    check("b2b_uout_pin0", 32'(uout), 32'h0001);
    check("b2b_fout_off", 32'(fout), 32'h0);

    // T6: reset during DRAIN discards the pending word
    fin = 16'hFFFF;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_data  = 32'hFFFF_FFFF;
    tick();
    cfg.cfg_valid = 1'b0;
    tick();
    tick();
    resetn = 1'b0;
    #1;
    check("midrst_mode", cfg.mode_o, 32'h0);
    check("midrst_count", 32'(cfg.cfg_count), 32'd0);
    check("midrst_uout", 32'(uout), 32'h0);
    check("midrst_fout", 32'(fout), 32'h0);
    tick();
    resetn = 1'b1;
    repeat (SETTLE + 3) tick();
    check("midrst_no_apply_mode", cfg.mode_o, 32'h0);
    check("midrst_no_apply_count", 32'(cfg.cfg_count), 32'd0);
    check("midrst_ready", 32'(cfg.cfg_ready), 32'd1);
    check("midrst_uout_after", 32'(uout), 32'h0);

    // Identical words still run the full sequence; counter wraps after 256 applies
    for (int i = 0; i < 255; i++) cfg_apply(32'h0000_0003, low);
    check("wrap_count_255", 32'(cfg.cfg_count), 32'd255);
    cfg_apply(32'h0000_0003, low);
    check("wrap_identical_low_cycles", low, SETTLE + 1);
    check("wrap_count_0", 32'(cfg.cfg_count), 32'd0);
    check("wrap_mode", cfg.mode_o, 32'h0000_0003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
